// File: rtl/pwm_multi_channel.sv
// N-channel PWM generator with a register-mapped slave port and shadowed PERIOD/DUTY.
// Define PWM_CENTER_ALIGNED_EN to enable center-aligned (up/down) counting via CTRL[1].
`timescale 1ns/1ps
module pwm_multi_channel #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_tick
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_PERIOD   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_PRESCALE = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_CHEN     = ADDR_W'(3);
  localparam int                DUTY_BASE     = 4;

  logic              ctrl_en_q, ctrl_en_d;
  logic              center_mode;
  logic [CNT_W-1:0]  period_sh_q, period_sh_d;
  logic [CNT_W-1:0]  period_act_q, period_act_d;
  logic [PRE_W-1:0]  prescale_q, prescale_d;
  logic [NUM_CH-1:0] chen_q, chen_d;
  logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_down_q, dir_down_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              period_tick_q, period_tick_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              tick;
  logic              boundary;
  logic              unused_wr_data;

`ifdef PWM_CENTER_ALIGNED_EN
  logic ctrl_center_q, ctrl_center_d;
  assign center_mode = ctrl_center_q;
`else
  assign center_mode = 1'b0;
`endif

  // Upper wr_data bits are architecturally ignored.
  assign unused_wr_data = ^wr_data;

  always_comb begin
    // NOTE: every _d signal takes its hold value first, so no path through this block can infer a latch.
    ctrl_en_d     = ctrl_en_q;
`ifdef PWM_CENTER_ALIGNED_EN
    ctrl_center_d = ctrl_center_q;
`endif
    period_sh_d   = period_sh_q;
    period_act_d  = period_act_q;
    prescale_d    = prescale_q;
    chen_d        = chen_q;
    duty_sh_d     = duty_sh_q;
    duty_act_d    = duty_act_q;
    pre_cnt_d     = pre_cnt_q;
    cnt_d         = cnt_q;
    dir_down_d    = dir_down_q;
    pwm_d         = '0;
    period_tick_d = 1'b0;
    rd_data_d     = rd_data_q;
    tick          = 1'b0;
    boundary      = 1'b0;

    // Reads see the shadow registers as they were before any same-cycle write.
    if (rd_en) begin
      rd_data_d = '0;
      if (addr == ADDR_CTRL)          rd_data_d = DATA_W'({center_mode, ctrl_en_q});
      else if (addr == ADDR_PERIOD)   rd_data_d = DATA_W'(period_sh_q);
      else if (addr == ADDR_PRESCALE) rd_data_d = DATA_W'(prescale_q);
      else if (addr == ADDR_CHEN)     rd_data_d = DATA_W'(chen_q);
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_W'(DUTY_BASE + i)) rd_data_d = DATA_W'(duty_sh_q[i]);
      end
    end

    if (ctrl_en_q) begin
      tick      = (pre_cnt_q >= prescale_q);
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      if (tick) begin
        if (!center_mode) begin
          cnt_d      = (cnt_q >= period_act_q) ? '0 : cnt_q + CNT_W'(1);
          dir_down_d = 1'b0;
        end else if ((dir_down_q && cnt_q != '0) ||
                     (cnt_q >= period_act_q && period_act_q != '0)) begin
          cnt_d      = cnt_q - CNT_W'(1);
          dir_down_d = 1'b1;
        end else if (cnt_q >= period_act_q) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Arriving at zero is the period boundary in both counting modes.
        boundary = (cnt_d == '0);
        if (boundary) dir_down_d = 1'b0;
      end
      period_tick_d = boundary;
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_d[i] = chen_q[i] & (cnt_q < duty_act_q[i]);
      end
      if (boundary) begin
        period_act_d = period_sh_q;
        duty_act_d   = duty_sh_q;
      end
    end else begin
      pre_cnt_d    = '0;
      cnt_d        = '0;
      dir_down_d   = 1'b0;
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end

    if (wr_en) begin
      if (addr == ADDR_CTRL) begin
        ctrl_en_d = wr_data[0];
`ifdef PWM_CENTER_ALIGNED_EN
        ctrl_center_d = wr_data[1];
`endif
      end
      if (addr == ADDR_PERIOD)   period_sh_d = wr_data[CNT_W-1:0];
      if (addr == ADDR_PRESCALE) prescale_d  = wr_data[PRE_W-1:0];
      if (addr == ADDR_CHEN)     chen_d      = wr_data[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == ADDR_W'(DUTY_BASE + i)) duty_sh_d[i] = wr_data[CNT_W-1:0];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments only; blocking belongs in the always_comb above.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ctrl_en_q     <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      ctrl_center_q <= 1'b0;
`endif
      period_sh_q   <= '0;
      period_act_q  <= '0;
      prescale_q    <= '0;
      chen_q        <= '0;
      // NOTE: the duty arrays are flop banks that software reads back, so they are reset like any register.
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
      pre_cnt_q     <= '0;
      cnt_q         <= '0;
      dir_down_q    <= 1'b0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      ctrl_en_q     <= ctrl_en_d;
`ifdef PWM_CENTER_ALIGNED_EN
      ctrl_center_q <= ctrl_center_d;
`endif
      period_sh_q   <= period_sh_d;
      period_act_q  <= period_act_d;
      prescale_q    <= prescale_d;
      chen_q        <= chen_d;
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      pre_cnt_q     <= pre_cnt_d;
      cnt_q         <= cnt_d;
      dir_down_q    <= dir_down_d;
      pwm_q         <= pwm_d;
      period_tick_q <= period_tick_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: directed scenarios plus randomized register traffic
// checked against a position-in-period reference model.
`timescale 1ns/1ps
module tb_pwm_multi_channel;
  localparam int NUM_CH = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        wr_en, rd_en;
  logic [3:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  pwm_out;
  logic        period_tick;

  always #5 clk_clk = ~clk_clk;

  pwm_multi_channel dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: tracks elapsed ticks within the current period and derives
  // the counter value from that position with plain arithmetic.
  bit          m_en, m_center;
  int          m_period_sh, m_period_act, m_pre, m_chen, m_pc, m_t;
  int          m_duty_sh [NUM_CH];
  int          m_duty_act[NUM_CH];
  logic [7:0]  exp_pwm;
  logic        exp_tick;
  logic [31:0] exp_rd;

  task automatic model_reset();
    m_en = 0; m_center = 0; m_period_sh = 0; m_period_act = 0; m_pre = 0;
    m_chen = 0; m_pc = 0; m_t = 0;
    for (int i = 0; i < NUM_CH; i++) begin m_duty_sh[i] = 0; m_duty_act[i] = 0; end
    exp_pwm = '0; exp_tick = 0; exp_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a == 0) return {30'd0, m_center, m_en};
    if (a == 1) return 32'(m_period_sh);
    if (a == 2) return 32'(m_pre);
    if (a == 3) return 32'(m_chen);
    if (a >= 4 && a < 4 + NUM_CH) return 32'(m_duty_sh[a-4]);
    return '0;
  endfunction

  task automatic model_step(input bit we, input bit re, input int a, input logic [31:0] d);
    int cnt, len;
    bit tk, bnd;
    if (re) exp_rd = model_read(a);
    bnd = 0;
    if (m_en) begin
      cnt = (m_center && m_t > m_period_act) ? 2 * m_period_act - m_t : m_t;
      for (int i = 0; i < NUM_CH; i++)
        exp_pwm[i] = (((m_chen >> i) & 1) != 0) && (cnt < m_duty_act[i]);
      tk = (m_pc >= m_pre);
      m_pc = tk ? 0 : m_pc + 1;
      if (tk) begin
        m_t++;
        len = m_center ? ((m_period_act == 0) ? 1 : 2 * m_period_act) : m_period_act + 1;
        if (m_t >= len) begin m_t = 0; bnd = 1; end
      end
      exp_tick = bnd;
    end else begin
      exp_pwm = '0; exp_tick = 0; m_pc = 0; m_t = 0; bnd = 1;
    end
    if (bnd) begin m_period_act = m_period_sh; m_duty_act = m_duty_sh; end
    if (we) begin
      if (a == 0) begin
        m_en = d[0];
`ifdef PWM_CENTER_ALIGNED_EN
        m_center = d[1];
`endif
      end
      if (a == 1) m_period_sh = int'(d[15:0]);
      if (a == 2) m_pre = int'(d[15:0]);
      if (a == 3) m_chen = int'(d[7:0]);
      if (a >= 4 && a < 4 + NUM_CH) m_duty_sh[a-4] = int'(d[15:0]);
    end
  endtask

  // Drives one bus cycle from a negedge, advances the model at the posedge, returns at the next negedge.
  task automatic cycle(input bit we, input bit re, input int a, input logic [31:0] d);
    wr_en = we; rd_en = re; addr = a[3:0]; wr_data = d;
    @(posedge clk_clk);
    model_step(we, re, a, d);
    @(negedge clk_clk);
    wr_en = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    reset_reset = 1;
    model_reset();
    repeat (2) @(negedge clk_clk);
    vectors++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0 || rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs pwm=%h tick=%b rd=%h, wanted all zero", pwm_out, period_tick, rd_data);
    end
    reset_reset = 0;
    for (int a = 0; a < 16; a++) begin
      cycle(0, 1, a, 0);
      vectors++;
      if (rd_data !== exp_rd) begin
        miscompares++;
        $display("FAIL reset_readback addr=%0d rd=%h expected %h", a, rd_data, exp_rd);
      end
    end
  endtask

  task automatic test_edge_basic();
    int hi = 0, tk = 0;
    cycle(1, 0, 2, 0); cycle(1, 0, 1, 9); cycle(1, 0, 4, 3); cycle(1, 0, 3, 1); cycle(1, 0, 0, 1);
    for (int c = 0; c < 40; c++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (pwm_out !== exp_pwm || period_tick !== exp_tick || rd_data !== exp_rd) begin
        miscompares++;
        $display("FAIL edge_basic c=%0d pwm=%h exp %h tick=%b exp %b rd=%h exp %h",
                 c, pwm_out, exp_pwm, period_tick, exp_tick, rd_data, exp_rd);
      end
      if (c >= 20) begin hi += int'(pwm_out[0]); tk += int'(period_tick); end
    end
    vectors++;
    if (hi != 6 || tk != 2) begin
      miscompares++;
      $display("FAIL edge_duty_count high=%0d ticks=%0d expected 6 and 2 in 20 clks", hi, tk);
    end
  endtask

  task automatic test_prescale();
    int hi = 0, tk = 0;
    cycle(1, 0, 0, 0); cycle(1, 0, 2, 4); cycle(1, 0, 0, 1);
    for (int c = 0; c < 160; c++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (pwm_out !== exp_pwm || period_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL prescale c=%0d pwm=%h exp %h tick=%b exp %b", c, pwm_out, exp_pwm, period_tick, exp_tick);
      end
      if (c >= 60) begin hi += int'(pwm_out[0]); tk += int'(period_tick); end
    end
    vectors++;
    if (hi != 30 || tk != 2) begin
      miscompares++;
      $display("FAIL prescale_count high=%0d ticks=%0d expected 30 and 2 in 100 clks", hi, tk);
    end
  endtask

  task automatic test_shadow_update();
    int want[4] = '{3, 7, 7, 2};
    int hi, budget;
    cycle(1, 0, 0, 0); cycle(1, 0, 2, 0); cycle(1, 0, 0, 1);
    budget = 0;
    while (period_tick !== 1'b1 && budget < 40) begin cycle(0, 0, 0, 0); budget++; end
    vectors++;
    if (period_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL shadow_wait_tick no period_tick within 40 clks");
    end
    for (int p = 0; p < 4; p++) begin
      hi = 0;
      for (int j = 1; j <= 10; j++) begin
        if (p == 0 && j == 5)       cycle(1, 0, 4, 7);
        else if (p == 0 && j == 6)  cycle(0, 1, 4, 0);
        else if (p == 1 && j == 10) cycle(1, 0, 4, 2);
        else                        cycle(0, 0, 0, 0);
        vectors++;
        if (pwm_out !== exp_pwm || period_tick !== exp_tick || rd_data !== exp_rd) begin
          miscompares++;
          $display("FAIL shadow p=%0d j=%0d pwm=%h exp %h tick=%b exp %b rd=%h exp %h",
                   p, j, pwm_out, exp_pwm, period_tick, exp_tick, rd_data, exp_rd);
        end
        if (p == 0 && j == 6) begin
          vectors++;
          if (rd_data !== 32'd7) begin
            miscompares++;
            $display("FAIL shadow_readback rd=%h expected 00000007", rd_data);
          end
        end
        hi += int'(pwm_out[0]);
      end
      vectors++;
      if (hi != want[p]) begin
        miscompares++;
        $display("FAIL shadow_period_high p=%0d high=%0d expected %0d", p, hi, want[p]);
      end
    end
  endtask

  task automatic test_duty_extremes();
    cycle(1, 0, 0, 0); cycle(1, 0, 5, 0); cycle(1, 0, 6, 10); cycle(1, 0, 3, 7); cycle(1, 0, 0, 1);
    for (int c = 0; c < 30; c++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (pwm_out !== exp_pwm || period_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL extremes c=%0d pwm=%h exp %h tick=%b exp %b", c, pwm_out, exp_pwm, period_tick, exp_tick);
      end
      if (c >= 1) begin
        vectors++;
        if (pwm_out[1] !== 1'b0 || pwm_out[2] !== 1'b1) begin
          miscompares++;
          $display("FAIL extremes_const c=%0d pwm1=%b pwm2=%b expected 0 and 1", c, pwm_out[1], pwm_out[2]);
        end
      end
    end
  endtask

  task automatic test_random(input bit center);
    int a, r;
    logic [31:0] d;
    for (int round = 0; round < 4; round++) begin
      cycle(1, 0, 0, 0);
      cycle(1, 0, 2, $urandom_range(0, 3));
      cycle(1, 0, 1, $urandom_range(0, 12));
      cycle(1, 0, 3, $urandom);
      for (int i = 0; i < NUM_CH; i++) cycle(1, 0, 4 + i, $urandom_range(0, 15));
      cycle(1, 0, 0, {30'd0, center, 1'b1});
      for (int c = 0; c < 150; c++) begin
        a = $urandom_range(0, 15);
        d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 14));
        if (a == 3) d = $urandom;
        if (a == 0) d = ($urandom & 32'hFFFF_FFFC) | {30'd0, center, ($urandom_range(0, 5) != 0)};
        r = $urandom_range(0, 9);
        if (r < 3)      cycle(1, 0, a, d);
        else if (r < 6) cycle(0, 1, a, 0);
        else if (r < 7) cycle(1, 1, a, d);
        else            cycle(0, 0, 0, 0);
        vectors++;
        if (pwm_out !== exp_pwm || period_tick !== exp_tick || rd_data !== exp_rd) begin
          miscompares++;
          $display("FAIL random ctr=%0d rnd=%0d c=%0d pwm=%h exp %h tick=%b exp %b rd=%h exp %h",
                   center, round, c, pwm_out, exp_pwm, period_tick, exp_tick, rd_data, exp_rd);
        end
      end
    end
  endtask

`ifdef PWM_CENTER_ALIGNED_EN
  task automatic test_center();
    int hi = 0, tk = 0;
    cycle(1, 0, 0, 0); cycle(1, 0, 2, 0); cycle(1, 0, 1, 4); cycle(1, 0, 4, 2);
    cycle(1, 0, 3, 1); cycle(1, 0, 0, 3);
    for (int c = 0; c < 40; c++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (pwm_out !== exp_pwm || period_tick !== exp_tick) begin
        miscompares++;
        $display("FAIL center c=%0d pwm=%h exp %h tick=%b exp %b", c, pwm_out, exp_pwm, period_tick, exp_tick);
      end
      if (c >= 24) begin hi += int'(pwm_out[0]); tk += int'(period_tick); end
    end
    vectors++;
    if (hi != 6 || tk != 2) begin
      miscompares++;
      $display("FAIL center_count high=%0d ticks=%0d expected 6 and 2 in 16 clks", hi, tk);
    end
  endtask
`else
  task automatic test_no_center();
    cycle(1, 0, 0, 3); cycle(0, 1, 0, 0);
    vectors++;
    if (rd_data !== 32'h1) begin
      miscompares++;
      $display("FAIL ctrl_center_bit rd=%h expected 00000001", rd_data);
    end
    cycle(1, 0, 0, 0);
  endtask
`endif

  task automatic test_reset_mid_period();
    int budget = 0;
    cycle(1, 0, 0, 0); cycle(1, 0, 2, 0); cycle(1, 0, 1, 9); cycle(1, 0, 4, 6);
    cycle(1, 0, 3, 1); cycle(1, 0, 0, 1);
    while (period_tick !== 1'b1 && budget < 40) begin cycle(0, 0, 0, 0); budget++; end
    cycle(0, 1, 0, 0);
    repeat (4) cycle(0, 0, 0, 0);
    vectors++;
    if (pwm_out !== exp_pwm || rd_data !== exp_rd || pwm_out[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset pwm=%h exp %h rd=%h exp %h", pwm_out, exp_pwm, rd_data, exp_rd);
    end
    #2 reset_reset = 1;
    #1;
    vectors++;
    if (pwm_out !== 8'h00 || period_tick !== 1'b0 || rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset pwm=%h tick=%b rd=%h, wanted all zero", pwm_out, period_tick, rd_data);
    end
    model_reset();
    @(negedge clk_clk);
    reset_reset = 0;
    cycle(0, 1, 0, 0);
    vectors++;
    if (rd_data !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_ctrl rd=%h expected 00000000", rd_data);
    end
    for (int c = 0; c < 20; c++) begin
      cycle(0, 0, 0, 0);
      vectors++;
      if (pwm_out !== 8'h00 || period_tick !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle c=%0d pwm=%h tick=%b expected 0", c, pwm_out, period_tick);
      end
    end
  endtask

  initial begin
    reset_reset = 1; wr_en = 0; rd_en = 0; addr = '0; wr_data = '0;
    model_reset();
    test_reset();
    test_edge_basic();
    test_prescale();
    test_shadow_update();
    test_duty_extremes();
    test_random(1'b0);
`ifdef PWM_CENTER_ALIGNED_EN
    test_center();
    test_random(1'b1);
`else
    test_no_center();
`endif
    test_reset_mid_period();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish within 2 ms");
    $fatal(1, "watchdog");
  end

endmodule
